// File: rtl/pulse_gate_pkg.sv
// Shared state encoding and level helpers for the multi-channel pulse gate.
package pulse_gate_pkg;

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    CLOSED = 2'd1,
    BURST  = 2'd2
  } gate_state_e;

  function automatic logic inactive_level(input logic active_level);
    return ~active_level;
  endfunction

endpackage

// File: rtl/pulse_gate_burst_channel.sv
// One gated pulse channel: level gate, counted burst, pending flag and optional
// dropped-pulse statistics (PULSE_GATE_BURST_STATS_EN).
module pulse_gate_burst_channel
  import pulse_gate_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH        = 8,
  parameter logic        PULSE_ACTIVE_LEVEL = 1'b1
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   clock_enable,
  input  logic                   pulse_in,
  input  logic                   gate_pulse,
  input  logic                   burst_load,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  output logic                   pulse_out,
  output logic                   gate_state,
  output logic                   burst_busy,
  output logic                   burst_done,
  output logic [COUNT_WIDTH-1:0] dropped_count
);

  localparam logic INACTIVE = inactive_level(PULSE_ACTIVE_LEVEL);

  gate_state_e            state_q, state_d;
  logic                   pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   prev_in_q;
  logic                   done_q, done_d;
  logic                   in_idle;
  logic                   pulse_end;

  assign in_idle   = (pulse_in == INACTIVE);
  assign pulse_end = (prev_in_q != INACTIVE) && in_idle;

  // Next-state: gate changes and burst entry only land on inactive cycles.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    if (burst_load && !burst_busy && (burst_count != '0)) begin
      pending_d = 1'b1;
      count_d   = burst_count;
    end
    case (state_q)
      BURST: begin
        if (pulse_end) begin
          count_d = count_q - COUNT_WIDTH'(1);
          if (count_q == COUNT_WIDTH'(1)) begin
            state_d = gate_pulse ? CLOSED : OPEN;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (in_idle) begin
          if (pending_q) begin
            state_d   = BURST;
            pending_d = 1'b0;
          end else begin
            state_d = gate_pulse ? CLOSED : OPEN;
          end
        end
      end
    endcase
  end

  // A stalled cycle ends a done pulse rather than stretching it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= OPEN;
      pending_q <= 1'b0;
      count_q   <= '0;
      prev_in_q <= INACTIVE;
      done_q    <= 1'b0;
    end else begin
      if (clock_enable) begin
        state_q   <= state_d;
        pending_q <= pending_d;
        count_q   <= count_d;
        prev_in_q <= pulse_in;
      end
      done_q <= clock_enable & done_d;
    end
  end

  assign pulse_out  = (state_q != CLOSED) ? pulse_in : INACTIVE;
  assign gate_state = (state_q == CLOSED);
  assign burst_busy = pending_q | (state_q == BURST);
  assign burst_done = done_q;

`ifdef PULSE_GATE_BURST_STATS_EN
  logic [COUNT_WIDTH-1:0] dropped_q;

  // Saturating count of whole pulses swallowed while closed.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dropped_q <= '0;
    end else if (clock_enable && (state_q == CLOSED) && pulse_end && (dropped_q != '1)) begin
      dropped_q <= dropped_q + COUNT_WIDTH'(1);
    end
  end

  assign dropped_count = dropped_q;
`else
  assign dropped_count = '0;
`endif

endmodule

// File: rtl/pulse_gate_burst.sv
// Multi-channel non-truncating pulse gate with counted bursts; optional
// per-channel dropped-pulse statistics under PULSE_GATE_BURST_STATS_EN.
module pulse_gate_burst
  import pulse_gate_pkg::*;
#(
  parameter int unsigned CHANNELS           = 4,
  parameter int unsigned COUNT_WIDTH        = 8,
  parameter logic        PULSE_ACTIVE_LEVEL = 1'b1
) (
  input  logic                            clock,
  input  logic                            clear,
  input  logic                            clock_enable,
  input  logic [CHANNELS-1:0]             pulses_in,
  input  logic [CHANNELS-1:0]             gate_pulses,
  input  logic [CHANNELS-1:0]             burst_load,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] burst_count,
  output logic [CHANNELS-1:0]             pulses_out,
  output logic [CHANNELS-1:0]             gate_state,
  output logic [CHANNELS-1:0]             burst_busy,
  output logic [CHANNELS-1:0]             burst_done,
  output logic [CHANNELS*COUNT_WIDTH-1:0] dropped_count
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pulse_gate_burst_channel #(
      .COUNT_WIDTH       (COUNT_WIDTH),
      .PULSE_ACTIVE_LEVEL(PULSE_ACTIVE_LEVEL)
    ) u_ch (
      .clock        (clock),
      .clear        (clear),
      .clock_enable (clock_enable),
      .pulse_in     (pulses_in[c]),
      .gate_pulse   (gate_pulses[c]),
      .burst_load   (burst_load[c]),
      .burst_count  (burst_count[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .pulse_out    (pulses_out[c]),
      .gate_state   (gate_state[c]),
      .burst_busy   (burst_busy[c]),
      .burst_done   (burst_done[c]),
      .dropped_count(dropped_count[c*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_pulse_gate_burst.sv
// Directed bench for pulse_gate_burst: level gating, bursts, clear, stats.
module tb_pulse_gate_burst;

  logic        clock;
  logic        clear;
  logic        clock_enable;
  logic [3:0]  pulses_in;
  logic [3:0]  gate_pulses;
  logic [3:0]  burst_load;
  logic [31:0] burst_count;
  logic [3:0]  pulses_out;
  logic [3:0]  gate_state;
  logic [3:0]  burst_busy;
  logic [3:0]  burst_done;
  logic [31:0] dropped_count;

  int tests = 0;
  int fails = 0;

  pulse_gate_burst dut (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (clock_enable),
    .pulses_in    (pulses_in),
    .gate_pulses  (gate_pulses),
    .burst_load   (burst_load),
    .burst_count  (burst_count),
    .pulses_out   (pulses_out),
    .gate_state   (gate_state),
    .burst_busy   (burst_busy),
    .burst_done   (burst_done),
    .dropped_count(dropped_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

`ifdef PULSE_GATE_BURST_STATS_EN
  localparam logic [7:0] EXP_DROP7   = 8'd7;
  localparam logic [7:0] EXP_DROPSAT = 8'd255;
`else
  localparam logic [7:0] EXP_DROP7   = 8'd0;
  localparam logic [7:0] EXP_DROPSAT = 8'd0;
`endif

  initial begin
    int rises;
    int done_cnt;
    int done_at;
    logic prev_out;

    clear        = 1'b1;
    clock_enable = 1'b1;
    pulses_in    = 4'b0001;
    gate_pulses  = 4'b0000;
    burst_load   = 4'b0000;
    burst_count  = '0;
    #2;
    // Reset state
    check("rst_out_follows", 32'(pulses_out), 32'h1);
    check("rst_gate_state", 32'(gate_state), 32'h0);
    check("rst_busy", 32'(burst_busy), 32'h0);
    check("rst_done", 32'(burst_done), 32'h0);
    check("rst_dropped", dropped_count, 32'h0);
    tick();
    clear = 1'b0;

    // 1: open gate passes a 3-cycle pulse unchanged
    pulses_in = 4'b0001; #1; check("t1_out_c1", 32'(pulses_out[0]), 32'h1); tick();
    pulses_in = 4'b0001; #1; check("t1_out_c2", 32'(pulses_out[0]), 32'h1); tick();
    pulses_in = 4'b0001; #1; check("t1_out_c3", 32'(pulses_out[0]), 32'h1); tick();
    pulses_in = 4'b0000; #1; check("t1_out_c4", 32'(pulses_out[0]), 32'h0);
    check("t1_gate_state", 32'(gate_state), 32'h0);
    check("t1_busy", 32'(burst_busy), 32'h0);
    tick();

    // Stalled clock loses the close request
    clock_enable = 1'b0; gate_pulses = 4'b0001; tick();
    clock_enable = 1'b1; gate_pulses = 4'b0000; #1;
    check("ce_hold_gate", 32'(gate_state[0]), 32'h0);
    tick();

    // 2: close request mid-pulse waits for the inactive period
    pulses_in = 4'b0010; #1; check("t2_out_c1", 32'(pulses_out[1]), 32'h1); tick();
    gate_pulses[1] = 1'b1; #1; check("t2_out_c2", 32'(pulses_out[1]), 32'h1); tick();
    #1; check("t2_out_c3", 32'(pulses_out[1]), 32'h1); tick();
    #1; check("t2_out_c4", 32'(pulses_out[1]), 32'h1);
    check("t2_gs_mid", 32'(gate_state[1]), 32'h0); tick();
    pulses_in = 4'b0000; #1; check("t2_gs_idle0", 32'(gate_state[1]), 32'h0); tick();
    #1; check("t2_gs_closed", 32'(gate_state[1]), 32'h1); tick();
    pulses_in = 4'b0010; #1; check("t2_blocked", 32'(pulses_out[1]), 32'h0); tick();
    pulses_in = 4'b0000; tick();

    // 3/4: closed ch2, zero-count load ignored, burst of 3 with a load while busy
    gate_pulses[2] = 1'b1; tick();
    #1; check("t3_closed", 32'(gate_state[2]), 32'h1);
    burst_load = 4'b0100; burst_count[16 +: 8] = 8'd0; tick();
    burst_load = 4'b0000; #1; check("t4_zero_ignored", 32'(burst_busy[2]), 32'h0);
    burst_load = 4'b0100; burst_count[16 +: 8] = 8'd3; tick();
    burst_load = 4'b0000; #1; check("t3_pending", 32'(burst_busy[2]), 32'h1); tick();
    #1; check("t3_in_burst", 32'(burst_busy[2]), 32'h1);
    rises = 0; done_cnt = 0; done_at = -1; prev_out = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pulses_in[2] = ((i % 4) < 2);
      burst_load = (i == 1) ? 4'b0100 : 4'b0000;
      burst_count[16 +: 8] = (i == 1) ? 8'd5 : 8'd3;
      #1;
      if (pulses_out[2] && !prev_out) rises++;
      prev_out = pulses_out[2];
      if (burst_done[2]) begin
        done_cnt++;
        done_at = i;
      end
      tick();
    end
    burst_load = 4'b0000;
    check("t3_pulses_passed", 32'(rises), 32'd3);
    check("t3_done_once", 32'(done_cnt), 32'd1);
    check("t3_done_cycle", 32'(done_at), 32'd11);
    check("t3_reclosed", 32'(gate_state[2]), 32'h1);
    check("t3_not_busy", 32'(burst_busy[2]), 32'h0);

    // 5: clear mid-burst with input active
    burst_load = 4'b1000; burst_count[24 +: 8] = 8'd2; pulses_in = 4'b0000; tick();
    burst_load = 4'b0000; #1; check("t5_pending", 32'(burst_busy[3]), 32'h1); tick();
    pulses_in = 4'b1010; gate_pulses[3] = 1'b1; #1;
    check("t5_burst_pass", 32'(pulses_out[3]), 32'h1);
    check("t5_ch1_blocked", 32'(pulses_out[1]), 32'h0);
    clear = 1'b1; #1;
    check("t5_clr_pass", 32'(pulses_out[3]), 32'h1);
    check("t5_clr_runt", 32'(pulses_out[1]), 32'h1);
    check("t5_clr_busy", 32'(burst_busy), 32'h0);
    check("t5_clr_gs", 32'(gate_state), 32'h0);
    tick();
    clear = 1'b0; pulses_in = 4'b0000; gate_pulses = 4'b0000;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (burst_done != 4'b0000) done_cnt++;
      tick();
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);

    // 6: dropped pulse statistics on closed ch0
    gate_pulses[0] = 1'b1; tick();
    #1; check("t6_closed", 32'(gate_state[0]), 32'h1);
    for (int k = 0; k < 7; k++) begin
      pulses_in[0] = 1'b1; tick();
      pulses_in[0] = 1'b0; tick();
    end
    check("t6_dropped7", 32'(dropped_count[7:0]), 32'(EXP_DROP7));
    pulses_in[0] = 1'b1; #1; check("t6_blocked", 32'(pulses_out[0]), 32'h0);
    for (int k = 0; k < 259; k++) begin
      pulses_in[0] = 1'b1; tick();
      pulses_in[0] = 1'b0; tick();
    end
    check("t6_saturated", 32'(dropped_count[7:0]), 32'(EXP_DROPSAT));
    check("t6_other_ch", 32'(dropped_count[31:8]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
